mmss_up_cnt: RTL and testbench
==============================

MMSS_UP_CNT -- requirements
Module: mmss_up_cnt

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- CLOCK  input  1  single system clock; all state updates on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- EN  input  1  count tick; qualifies one count step per cycle.
- START  input  1  synchronous pulse; enters RUN.
- STOP  input  1  synchronous pulse; enters IDLE.
- CLR  input  1  synchronous clear of all digits to 00:00.
- LOAD  input  1  synchronous load of LD_* digits.
- LD_MH  input  3  minutes tens value to load (BCD, 0-5 valid).
- LD_ML  input  4  minutes units value to load (BCD, 0-9 valid).
- LD_SH  input  3  seconds tens value to load (BCD, 0-5 valid).
- LD_SL  input  4  seconds units value to load (BCD, 0-9 valid).
- MH  output  3  minutes tens digit, registered.
- ML  output  4  minutes units digit, registered.
- SH  output  3  seconds tens digit, registered.
- SL  output  4  seconds units digit, registered.
- RUNNING  output  1  high in RUN state, registered.
- CO  output  1  combinational carry out.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-003 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-004 IDLE -> RUN SHALL occur on a clock edge with START=1 and STOP=0.
REQ-005 RUN -> IDLE SHALL occur on a clock edge with STOP=1; STOP SHALL win when START and STOP are both 1.
REQ-006 RUNNING SHALL equal 1 exactly when the state is RUN.
REQ-007 A count step SHALL occur on a clock edge when the state (before the edge) is RUN, EN=1, CLR=0 and LOAD=0.
REQ-008 Digit-update priority per edge SHALL be: CLR, then LOAD, then count step, then hold.
REQ-009 CLR and LOAD SHALL act in either FSM state and SHALL NOT change the FSM state.
REQ-010 Count step carry chain: SL 9->0 carries into SH; SH 5->0 carries into ML; ML 9->0 carries into MH; MH 5->0 wraps.
REQ-011 A count step SHALL leave every digit above the first non-wrapping digit unchanged.
REQ-012 From 59:59 a count step SHALL give 00:00.
REQ-013 CO SHALL be 1 exactly when MH=5, ML=9, SH=5, SL=9, state=RUN, EN=1, CLR=0 and LOAD=0.
- CO is the up-count counterpart of a borrow-out; it SHALL be asserted in the cycle before the wrap to 00:00.
REQ-014 On LOAD, each digit SHALL take its LD_* value if that value is in range; an out-of-range LD_* digit SHALL load as 0.
- Example: LD_SL=12 loads SL=0; the other digits are unaffected by this rule.
REQ-015 Count latency SHALL be one cycle: outputs reflect the step on the same edge that samples EN.
REQ-016 Digits SHALL hold whenever no CLR, LOAD or count step applies, including the cycle in which START is sampled.
REQ-017 Digits SHALL never leave their legal ranges (SL, ML 0-9; SH, MH 0-5).

Reset
REQ-018 RESET_N=0 SHALL immediately, without a clock edge, force MH=ML=SH=SL=0, state IDLE, RUNNING=0 and CO=0.
REQ-019 Reset SHALL override all other inputs, including while asserted mid-count.
REQ-020 After RESET_N rises, the first state change SHALL be on a later rising CLOCK edge.

Verification
REQ-021 Reset, START pulse, then EN=1 for 61 cycles -> SH:SL steps 00..59, then MH:ML=01, SH:SL=00; then 01:01.
REQ-022 LOAD 59:58, START, EN=1 for 2 cycles -> 59:59 with CO=1 during that cycle; next edge -> 00:00, CO=0.
REQ-023 RUN, EN=1, LOAD 12:34 with CLR=1 on the same edge -> 00:00 (CLR wins); same case with CLR=0 -> 12:34, no increment that edge.
REQ-024 START and STOP on the same edge -> RUNNING=0; EN=1 for 5 cycles while IDLE -> digits unchanged, CO=0.
REQ-025 LOAD with LD_MH=7, LD_ML=3, LD_SH=6, LD_SL=15 -> 03:00.
REQ-026 Counting at 00:07, drive RESET_N low between clock edges -> outputs read 00:00 and RUNNING=0 before the next edge; counting stays stopped after release until START.

Source files
------------

// File: rtl/mmss_up_cnt.sv
// Minutes:seconds BCD up-counter (00:00 .. 59:59) with IDLE/RUN control.
// Clear, load and count share one digit update path with fixed priority.
module mmss_up_cnt (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       EN,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLR,
    input  logic       LOAD,
    input  logic [2:0] LD_MH,
    input  logic [3:0] LD_ML,
    input  logic [2:0] LD_SH,
    input  logic [3:0] LD_SL,
    output logic [2:0] MH,
    output logic [3:0] ML,
    output logic [2:0] SH,
    output logic [3:0] SL,
    output logic       RUNNING,
    output logic       CO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;

    logic       step;
    logic       sl_w;
    logic       sh_w;
    logic       ml_w;
    logic       mh_w;

    logic [2:0] ld_mh_v;
    logic [3:0] ld_ml_v;
    logic [2:0] ld_sh_v;
    logic [3:0] ld_sl_v;

    logic [2:0] mh_nxt;
    logic [3:0] ml_nxt;
    logic [2:0] sh_nxt;
    logic [3:0] sl_nxt;

    assign step = (state == RUN) && EN && !CLR && !LOAD;

    assign sl_w = (SL == 4'd9);
    assign sh_w = (SH == 3'd5);
    assign ml_w = (ML == 4'd9);
    assign mh_w = (MH == 3'd5);

    assign CO      = step && sl_w && sh_w && ml_w && mh_w;
    assign RUNNING = (state == RUN);

    // Out-of-range load digits are forced to zero so digits stay legal.
    assign ld_mh_v = (LD_MH <= 3'd5) ? LD_MH : 3'd0;
    assign ld_ml_v = (LD_ML <= 4'd9) ? LD_ML : 4'd0;
    assign ld_sh_v = (LD_SH <= 3'd5) ? LD_SH : 3'd0;
    assign ld_sl_v = (LD_SL <= 4'd9) ? LD_SL : 4'd0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (START && !STOP) state_nxt = RUN;
            RUN:  if (STOP)           state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mh_nxt = MH;
        ml_nxt = ML;
        sh_nxt = SH;
        sl_nxt = SL;
        if (CLR) begin
            mh_nxt = 3'd0;
            ml_nxt = 4'd0;
            sh_nxt = 3'd0;
            sl_nxt = 4'd0;
        end else if (LOAD) begin
            mh_nxt = ld_mh_v;
            ml_nxt = ld_ml_v;
            sh_nxt = ld_sh_v;
            sl_nxt = ld_sl_v;
        end else if (step) begin
            sl_nxt = sl_w ? 4'd0 : SL + 4'd1;
            if (sl_w) begin
                sh_nxt = sh_w ? 3'd0 : SH + 3'd1;
                if (sh_w) begin
                    ml_nxt = ml_w ? 4'd0 : ML + 4'd1;
                    if (ml_w) begin
                        mh_nxt = mh_w ? 3'd0 : MH + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            MH    <= 3'd0;
            ML    <= 4'd0;
            SH    <= 3'd0;
            SL    <= 4'd0;
        end else begin
            state <= state_nxt;
            MH    <= mh_nxt;
            ML    <= ml_nxt;
            SH    <= sh_nxt;
            SL    <= sl_nxt;
        end
    end

endmodule

// File: tb/tb_mmss_up_cnt.sv
// Directed testbench for mmss_up_cnt.
// Each task checks {MH,ML,SH,SL,RUNNING,CO} against hand-derived values.
module tb_mmss_up_cnt;

    logic       CLOCK;
    logic       RESET_N;
    logic       EN;
    logic       START;
    logic       STOP;
    logic       CLR;
    logic       LOAD;
    logic [2:0] LD_MH;
    logic [3:0] LD_ML;
    logic [2:0] LD_SH;
    logic [3:0] LD_SL;
    logic [2:0] MH;
    logic [3:0] ML;
    logic [2:0] SH;
    logic [3:0] SL;
    logic       RUNNING;
    logic       CO;

    int total;
    int bad;

    mmss_up_cnt dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .EN      (EN),
        .START   (START),
        .STOP    (STOP),
        .CLR     (CLR),
        .LOAD    (LOAD),
        .LD_MH   (LD_MH),
        .LD_ML   (LD_ML),
        .LD_SH   (LD_SH),
        .LD_SL   (LD_SL),
        .MH      (MH),
        .ML      (ML),
        .SH      (SH),
        .SL      (SL),
        .RUNNING (RUNNING),
        .CO      (CO)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    function automatic logic [15:0] exp_v(int m, int s, logic run, logic co);
        logic [2:0] mh;
        logic [3:0] ml;
        logic [2:0] sh;
        logic [3:0] sl;
        mh = 3'(m / 10);
        ml = 4'(m % 10);
        sh = 3'(s / 10);
        sl = 4'(s % 10);
        return {mh, ml, sh, sl, run, co};
    endfunction

    function automatic logic [15:0] obs();
        return {MH, ML, SH, SL, RUNNING, CO};
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        RESET_N = 1'b0;
        EN = 1'b0; START = 1'b0; STOP = 1'b0;
        CLR = 1'b0; LOAD = 1'b0;
        LD_MH = 3'd0; LD_ML = 4'd0; LD_SH = 3'd0; LD_SL = 4'd0;
        #2;
        e = exp_v(0, 0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs(), e);
        end
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_count_61();
        logic [15:0] e;
        START = 1'b1;
        tick();
        START = 1'b0;
        e = exp_v(0, 0, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL start_hold got=%h exp=%h", obs(), e);
        end
        EN = 1'b1;
        for (int i = 1; i <= 61; i++) begin
            tick();
            e = exp_v(i / 60, i % 60, 1'b1, 1'b0);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL count_%0d got=%h exp=%h", i, obs(), e);
            end
        end
        EN = 1'b0;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        e = exp_v(1, 1, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL count_stop got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        LOAD = 1'b1;
        LD_MH = 3'd5; LD_ML = 4'd9; LD_SH = 3'd5; LD_SL = 4'd8;
        tick();
        LOAD = 1'b0;
        e = exp_v(59, 58, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL wrap_load got=%h exp=%h", obs(), e);
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        EN = 1'b1;
        #1;
        e = exp_v(59, 58, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL wrap_start got=%h exp=%h", obs(), e);
        end
        tick();
        e = exp_v(59, 59, 1'b1, 1'b1);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL wrap_co got=%h exp=%h", obs(), e);
        end
        // CO must drop when LOAD masks the step at 59:59.
        LOAD = 1'b1;
        #1;
        e = exp_v(59, 59, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL wrap_co_load got=%h exp=%h", obs(), e);
        end
        LOAD = 1'b0;
        tick();
        e = exp_v(0, 0, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL wrap_zero got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_priority();
        logic [15:0] e;
        LD_MH = 3'd1; LD_ML = 4'd2; LD_SH = 3'd3; LD_SL = 4'd4;
        LOAD = 1'b1;
        CLR = 1'b1;
        tick();
        e = exp_v(0, 0, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL prio_clr got=%h exp=%h", obs(), e);
        end
        CLR = 1'b0;
        tick();
        LOAD = 1'b0;
        e = exp_v(12, 34, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL prio_load got=%h exp=%h", obs(), e);
        end
        tick();
        e = exp_v(12, 35, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL prio_count got=%h exp=%h", obs(), e);
        end
        EN = 1'b0;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
    endtask

    task automatic test_start_stop();
        logic [15:0] e;
        START = 1'b1;
        STOP = 1'b1;
        tick();
        START = 1'b0;
        STOP = 1'b0;
        EN = 1'b1;
        #1;
        e = exp_v(12, 35, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ss_idle got=%h exp=%h", obs(), e);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL ss_hold_%0d got=%h exp=%h", i, obs(), e);
            end
        end
        EN = 1'b0;
        START = 1'b1;
        tick();
        STOP = 1'b1;
        tick();
        START = 1'b0;
        STOP = 1'b0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ss_run_stop got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_load_range();
        logic [15:0] e;
        LOAD = 1'b1;
        LD_MH = 3'd7; LD_ML = 4'd3; LD_SH = 3'd6; LD_SL = 4'd15;
        tick();
        LOAD = 1'b0;
        e = exp_v(3, 0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL load_range got=%h exp=%h", obs(), e);
        end
        LOAD = 1'b1;
        LD_MH = 3'd6; LD_ML = 4'd10; LD_SH = 3'd5; LD_SL = 4'd9;
        tick();
        LOAD = 1'b0;
        e = exp_v(0, 59, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL load_edge got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        CLR = 1'b1;
        START = 1'b1;
        tick();
        CLR = 1'b0;
        START = 1'b0;
        EN = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        e = exp_v(0, 7, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ar_pre got=%h exp=%h", obs(), e);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        e = exp_v(0, 0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ar_async got=%h exp=%h", obs(), e);
        end
        START = 1'b1;
        LOAD = 1'b1;
        tick();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ar_override got=%h exp=%h", obs(), e);
        end
        START = 1'b0;
        LOAD = 1'b0;
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ar_stopped got=%h exp=%h", obs(), e);
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        e = exp_v(0, 0, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ar_restart got=%h exp=%h", obs(), e);
        end
        tick();
        e = exp_v(0, 1, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ar_resume got=%h exp=%h", obs(), e);
        end
        EN = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_count_61();
        test_wrap();
        test_priority();
        test_start_stop();
        test_load_range();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
